event_encoder: RTL and testbench
================================

Name: event_encoder

Overview:
- Sequential N-to-log2(N) encoder, the reverse of the team's 2-to-4 enable-gated decoder.
- Captures single-cycle event pulses on N request lines into a pending register.
- Emits the index of the highest-priority pending event as a binary code over a valid/ready handshake.
- Sits between interrupt/event sources and a consumer that must see one encoded event at a time, none lost.

Parameters:
- N, 4, number of request lines (2..16).
- W, 2, code width; must satisfy 2^W >= N (2 for the default).

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  asynchronous reset, active-high; clears all state immediately.
- en_n  input  1  capture enable, active-low; when high, new req pulses are ignored.
- req  input  N  event pulses; each bit sampled every clk edge.
- out_valid  output  1  out_code holds a valid event index.
- out_ready  input  1  consumer accepts out_code when high with out_valid.
- out_code  output  W  binary index of the presented event; highest index has priority.
- pending  output  N  registered pending-event vector (status).
- overflow  output  1  sticky: an event arrived on a line already pending.
- ovf_clr  input  1  synchronous clear of overflow.

Behaviour:
- Reset values: pending=0, out_valid=0, out_code=0, overflow=0, FSM=IDLE. Applied asynchronously on rst high, including mid-handshake; out_valid drops without waiting for a clock.
- Capture: pending_next = (pending & ~ack_mask) | (en_n ? 0 : req).
  - ack_mask is the one-hot mask of out_code when out_valid && out_ready, else 0.
- FSM has two states, IDLE and HOLD.
- IDLE:
  - If pending != 0, load out_code with the highest set index of pending, set out_valid=1, go to HOLD.
  - Else stay in IDLE with out_valid=0.
  - Priority uses the registered pending, not req.
- HOLD:
  - out_code and out_valid are held stable while out_ready=0. No change of code is allowed even if a higher-priority event arrives.
  - On out_valid && out_ready, that pending bit clears and out_valid=0 next cycle; go to IDLE.
- Latency:
  - req pulse at edge t → pending bit set after t → out_valid high after edge t+1 (2-cycle latency from an idle, empty state).
  - Throughput is one code per 2 cycles at most (1 handshake + 1 IDLE re-evaluation cycle).
- Simultaneous events:
  - req on the same bit being acknowledged this cycle: bit remains set (new event wins); no overflow.
  - req on a bit already pending and not being acknowledged: event merged, overflow set to 1.
  - Multiple req bits in one cycle: all captured; drained highest index first.
- Overflow: sticky until ovf_clr. If ovf_clr and a new overflow condition occur in the same cycle, overflow stays 1 (set wins). Events ignored due to en_n=1 never set overflow.
- en_n high: capture disabled only. Draining of existing pending bits and the handshake continue normally.
- out_ready without out_valid: no effect.
- Bits of req at indices >= N do not exist.
- When N < 2^W, codes >= N are never produced.

Test Plan:
- Reset, then pulse req=4'b0100 at cycle 1 with en_n=0, out_ready=1 → out_valid=1, out_code=2 at cycle 3; pending=0 after the handshake; out_valid=0 at cycle 4.
- Pulse req=4'b1011 in one cycle, out_ready=1 → codes 3, 1, 0 appear in order, each valid for 1 cycle with a 1-cycle gap; overflow=0.
- Hold out_ready=0 with code 1 presented, then pulse req[3] → out_code stays 1 until out_ready=1. The next code presented is 3; pending shows 4'b1010 before the ack.
- Pulse req[2] twice before it is acknowledged → overflow=1. Assert ovf_clr alone → overflow=0. Assert ovf_clr together with a fresh duplicate → overflow stays 1.
- en_n=1 with req=4'b1111 → pending unchanged, no new out_valid; existing pending events still drain. Pulse req[0] on the exact ack cycle of code 0 → code 0 is presented again 2 cycles later.
- Assert rst asynchronously mid-HOLD with pending=4'b0110 → out_valid, out_code, pending and overflow are all 0 before the next clk edge; normal operation resumes after rst deasserts.

Source files
------------

// File: rtl/event_encoder.sv
// Sequential N-to-log2(N) event encoder: latches request pulses into a pending
// vector and presents the highest pending index over a valid/ready handshake.
module event_encoder #(
  parameter int N = 4,
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en_n,
  input  logic [N-1:0] req,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_code,
  output logic [N-1:0] pending,
  output logic         overflow,
  input  logic         ovf_clr
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] HOLD = 1'b1;

  logic [0:0]   state_r;
  logic [0:0]   state_next_s;
  logic         ack_s;
  logic [N-1:0] ack_mask_s;
  logic [N-1:0] cap_s;
  logic [N-1:0] pending_next_s;
  logic         ovf_set_s;
  logic         overflow_next_s;
  logic         valid_next_s;
  logic [W-1:0] code_next_s;

  // Highest set index wins; later loop iterations override lower ones.
  function automatic logic [W-1:0] hi_index(input logic [N-1:0] v);
    logic [W-1:0] idx;
    idx = {W{1'b0}};
    for (int i = 0; i < N; i++) begin
      idx = v[i] ? W'(i) : idx;
    end
    return idx;
  endfunction

  // Capture, acknowledge, overflow and FSM next-state logic.
  always_comb begin
    ack_s           = out_valid & out_ready;
    ack_mask_s      = ack_s ? ({{(N-1){1'b0}}, 1'b1} << out_code) : {N{1'b0}};
    cap_s           = en_n ? {N{1'b0}} : req;
    pending_next_s  = (pending & ~ack_mask_s) | cap_s;
    // A bit being acknowledged this cycle may be re-armed without overflow.
    ovf_set_s       = |(cap_s & pending & ~ack_mask_s);
    overflow_next_s = ovf_set_s | (overflow & ~ovf_clr);
    state_next_s    = state_r;
    valid_next_s    = out_valid;
    code_next_s     = out_code;
    case (state_r)
      IDLE: begin
        if (pending != {N{1'b0}}) begin
          code_next_s  = hi_index(pending);
          valid_next_s = 1'b1;
          state_next_s = HOLD;
        end else begin
          valid_next_s = 1'b0;
          state_next_s = IDLE;
        end
      end
      HOLD: begin
        if (out_ready) begin
          valid_next_s = 1'b0;
          state_next_s = IDLE;
        end else begin
          valid_next_s = 1'b1;
          state_next_s = HOLD;
        end
      end
      default: begin
        valid_next_s = 1'b0;
        state_next_s = IDLE;
      end
    endcase
  end

  // State and output registers with asynchronous clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r   <= IDLE;
      pending   <= {N{1'b0}};
      out_valid <= 1'b0;
      out_code  <= {W{1'b0}};
      overflow  <= 1'b0;
    end else begin
      state_r   <= state_next_s;
      pending   <= pending_next_s;
      out_valid <= valid_next_s;
      out_code  <= code_next_s;
      overflow  <= overflow_next_s;
    end
  end

endmodule

// File: tb/tb_event_encoder.sv
// Directed self-checking bench for event_encoder (N=4, W=2).
module tb_event_encoder;

  logic       clk = 1'b0;
  logic       rst;
  logic       en_n;
  logic [3:0] req;
  logic       out_valid;
  logic       out_ready;
  logic [1:0] out_code;
  logic [3:0] pending;
  logic       overflow;
  logic       ovf_clr;

  int total = 0;
  int bad   = 0;

  event_encoder #(.N(4), .W(2)) dut (
    .clk(clk), .rst(rst), .en_n(en_n), .req(req),
    .out_valid(out_valid), .out_ready(out_ready), .out_code(out_code),
    .pending(pending), .overflow(overflow), .ovf_clr(ovf_clr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; en_n = 1'b0; req = 4'b0000; out_ready = 1'b0; ovf_clr = 1'b0;
    #1;
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_code", 32'(out_code), 32'd0);
    chk("rst_pending", 32'(pending), 32'd0);
    chk("rst_ovf", 32'(overflow), 32'd0);
    tick(); tick();
    @(negedge clk);
    rst = 1'b0;

    // single event, code 2
    out_ready = 1'b1; req = 4'b0100;
    tick(); req = 4'b0000;
    chk("t1_pend", 32'(pending), 32'h4);
    chk("t1_v0", 32'(out_valid), 32'd0);
    tick();
    chk("t1_v1", 32'(out_valid), 32'd1);
    chk("t1_code", 32'(out_code), 32'd2);
    tick();
    chk("t1_v_ack", 32'(out_valid), 32'd0);
    chk("t1_pend_ack", 32'(pending), 32'h0);
    tick();
    chk("t1_v_idle", 32'(out_valid), 32'd0);

    // multiple events drained 3,1,0
    req = 4'b1011;
    tick(); req = 4'b0000;
    chk("t2_pend", 32'(pending), 32'hB);
    tick();
    chk("t2_v3", 32'(out_valid), 32'd1);
    chk("t2_c3", 32'(out_code), 32'd3);
    tick();
    chk("t2_gap1", 32'(out_valid), 32'd0);
    chk("t2_pend1", 32'(pending), 32'h3);
    tick();
    chk("t2_v1", 32'(out_valid), 32'd1);
    chk("t2_c1", 32'(out_code), 32'd1);
    tick();
    chk("t2_gap2", 32'(out_valid), 32'd0);
    chk("t2_pend2", 32'(pending), 32'h1);
    tick();
    chk("t2_v0", 32'(out_valid), 32'd1);
    chk("t2_c0", 32'(out_code), 32'd0);
    tick();
    chk("t2_end_v", 32'(out_valid), 32'd0);
    chk("t2_end_p", 32'(pending), 32'h0);
    chk("t2_ovf", 32'(overflow), 32'd0);

    // held code not preempted by higher priority
    out_ready = 1'b0; req = 4'b0010;
    tick(); req = 4'b0000;
    tick();
    chk("t3_v", 32'(out_valid), 32'd1);
    chk("t3_c", 32'(out_code), 32'd1);
    req = 4'b1000;
    tick(); req = 4'b0000;
    chk("t3_hold_c", 32'(out_code), 32'd1);
    chk("t3_hold_v", 32'(out_valid), 32'd1);
    chk("t3_pend", 32'(pending), 32'hA);
    tick();
    chk("t3_hold_c2", 32'(out_code), 32'd1);
    out_ready = 1'b1;
    tick();
    chk("t3_ack_v", 32'(out_valid), 32'd0);
    chk("t3_ack_p", 32'(pending), 32'h8);
    tick();
    chk("t3_next_v", 32'(out_valid), 32'd1);
    chk("t3_next_c", 32'(out_code), 32'd3);
    tick();
    chk("t3_end_p", 32'(pending), 32'h0);

    // overflow set, clear, and set-wins-over-clear
    out_ready = 1'b0; req = 4'b0100;
    tick(); req = 4'b0000;
    chk("t4_ovf0", 32'(overflow), 32'd0);
    tick();
    chk("t4_c", 32'(out_code), 32'd2);
    req = 4'b0100;
    tick(); req = 4'b0000;
    chk("t4_ovf1", 32'(overflow), 32'd1);
    chk("t4_pend", 32'(pending), 32'h4);
    ovf_clr = 1'b1;
    tick();
    chk("t4_clr", 32'(overflow), 32'd0);
    req = 4'b0100;
    tick(); req = 4'b0000; ovf_clr = 1'b0;
    chk("t4_setwins", 32'(overflow), 32'd1);
    out_ready = 1'b1;
    tick();
    chk("t4_ack_p", 32'(pending), 32'h0);
    chk("t4_sticky", 32'(overflow), 32'd1);
    ovf_clr = 1'b1;
    tick(); ovf_clr = 1'b0;
    chk("t4_clr2", 32'(overflow), 32'd0);

    // en_n blocks capture only
    en_n = 1'b1; req = 4'b1111;
    tick();
    chk("t5_blk_p", 32'(pending), 32'h0);
    tick();
    chk("t5_blk_v", 32'(out_valid), 32'd0);
    chk("t5_blk_ovf", 32'(overflow), 32'd0);
    en_n = 1'b0; req = 4'b0001;
    tick(); en_n = 1'b1; req = 4'b1111;
    tick();
    chk("t5_v", 32'(out_valid), 32'd1);
    chk("t5_c", 32'(out_code), 32'd0);
    chk("t5_p", 32'(pending), 32'h1);
    chk("t5_ovf", 32'(overflow), 32'd0);
    tick();
    chk("t5_drain_v", 32'(out_valid), 32'd0);
    chk("t5_drain_p", 32'(pending), 32'h0);
    // re-arm on the exact ack cycle
    en_n = 1'b0; req = 4'b0001;
    tick(); req = 4'b0000;
    tick();
    chk("t5_ra_v", 32'(out_valid), 32'd1);
    req = 4'b0001;
    tick(); req = 4'b0000;
    chk("t5_ra_ackv", 32'(out_valid), 32'd0);
    chk("t5_ra_p", 32'(pending), 32'h1);
    chk("t5_ra_ovf", 32'(overflow), 32'd0);
    tick();
    chk("t5_ra_again_v", 32'(out_valid), 32'd1);
    chk("t5_ra_again_c", 32'(out_code), 32'd0);
    tick();
    chk("t5_ra_end_p", 32'(pending), 32'h0);

    // asynchronous reset mid-HOLD
    out_ready = 1'b0; req = 4'b0110;
    tick(); req = 4'b0000;
    tick();
    chk("t6_v", 32'(out_valid), 32'd1);
    chk("t6_c", 32'(out_code), 32'd2);
    req = 4'b0100;
    tick(); req = 4'b0000;
    chk("t6_ovf", 32'(overflow), 32'd1);
    chk("t6_p", 32'(pending), 32'h6);
    #2 rst = 1'b1;
    #1;
    chk("t6_rst_v", 32'(out_valid), 32'd0);
    chk("t6_rst_c", 32'(out_code), 32'd0);
    chk("t6_rst_p", 32'(pending), 32'h0);
    chk("t6_rst_ovf", 32'(overflow), 32'd0);
    @(negedge clk);
    rst = 1'b0; out_ready = 1'b1; req = 4'b1000;
    tick(); req = 4'b0000;
    tick();
    chk("t6_resume_v", 32'(out_valid), 32'd1);
    chk("t6_resume_c", 32'(out_code), 32'd3);
    tick();
    chk("t6_resume_end_v", 32'(out_valid), 32'd0);
    chk("t6_resume_end_p", 32'(pending), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
